// File: rtl/line_draw_engine.sv
// Bresenham line rasteriser: latches endpoints on a DataValid rising edge
// and streams one pixel per valid/ready handshake to the framebuffer writer.
module line_draw_engine #(
    parameter int COORD_W = 9,
    parameter int ERR_W   = COORD_W + 2
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COORD_W-1:0] x2,
    input  logic [COORD_W-1:0] y2,
    input  logic               DataValid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_valid,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

    state_t state, state_nxt;

    logic                      dv_q;
    logic                      start;
    logic [COORD_W-1:0]        xa, ya, xb, yb;
    logic [COORD_W-1:0]        absx, absy;
    logic signed [ERR_W-1:0]   adx, ady;
    logic signed [ERR_W-1:0]   dx, dy, err;
    logic signed [ERR_W:0]     e2, dx_e, dy_e;
    logic                      sx_neg, sy_neg;
    logic                      fire, last, step_x, step_y;

    assign start = DataValid & ~dv_q;
    assign fire  = pix_valid & pix_ready;
    assign last  = (pix_x == xb) && (pix_y == yb);

    assign absx = (xb >= xa) ? xb - xa : xa - xb;
    assign absy = (yb >= ya) ? yb - ya : ya - yb;
    assign adx  = $signed({{(ERR_W-COORD_W){1'b0}}, absx});
    assign ady  = $signed({{(ERR_W-COORD_W){1'b0}}, absy});

    // One extra bit so 2*err and the sign-extended deltas compare safely
    assign e2     = $signed({err, 1'b0});
    assign dx_e   = $signed({dx[ERR_W-1], dx});
    assign dy_e   = $signed({dy[ERR_W-1], dy});
    assign step_x = (e2 >= dy_e);
    assign step_y = (e2 <= dx_e);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE:  if (start) state_nxt = SETUP;
            SETUP: begin
                busy      = 1'b1;
                state_nxt = DRAW;
            end
            DRAW: begin
                busy = 1'b1;
                if (fire && last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dv_q      <= 1'b0;
            xa        <= '0;
            ya        <= '0;
            xb        <= '0;
            yb        <= '0;
            dx        <= '0;
            dy        <= '0;
            err       <= '0;
            sx_neg    <= 1'b0;
            sy_neg    <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_valid <= 1'b0;
        end else begin
            dv_q <= DataValid;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        xa <= x1;
                        ya <= y1;
                        xb <= x2;
                        yb <= y2;
                    end
                end
                SETUP: begin
                    dx        <= adx;
                    dy        <= -ady;
                    err       <= adx - ady;
                    sx_neg    <= (xb < xa);
                    sy_neg    <= (yb < ya);
                    pix_x     <= xa;
                    pix_y     <= ya;
                    pix_valid <= 1'b1;
                end
                DRAW: begin
                    if (fire) begin
                        if (last) begin
                            pix_valid <= 1'b0;
                        end else begin
                            err <= err + (step_x ? dy : '0) + (step_y ? dx : '0);
                            if (step_x)
                                pix_x <= sx_neg ? pix_x - COORD_W'(1) : pix_x + COORD_W'(1);
                            if (step_y)
                                pix_y <= sy_neg ? pix_y - COORD_W'(1) : pix_y + COORD_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_draw_engine.sv
// Self-checking bench for line_draw_engine: directed lines plus random
// lines compared against an integer Bresenham reference model.
module tb_line_draw_engine;

    localparam int COORD_W = 9;
    localparam int CMAX    = (1 << COORD_W) - 1;

    logic               HCLK = 1'b0;
    logic               HRESETn;
    logic [COORD_W-1:0] x1, y1, x2, y2;
    logic               DataValid;
    logic               pix_ready;
    logic [COORD_W-1:0] pix_x, pix_y;
    logic               pix_valid;
    logic               busy;
    logic               done;

    int n_chk  = 0;
    int n_fail = 0;

    int exp_x[$];
    int exp_y[$];

    line_draw_engine #(.COORD_W(COORD_W)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .x1        (x1),
        .y1        (y1),
        .x2        (x2),
        .y2        (y2),
        .DataValid (DataValid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_valid (pix_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input int got, input int want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference pixel list from the textbook integer Bresenham loop
    task automatic build_model(input int ax, input int ay, input int bx, input int by);
        int x, y, ddx, ddy, sx, sy, e, e2;
        exp_x.delete();
        exp_y.delete();
        x   = ax;
        y   = ay;
        ddx = iabs(bx - ax);
        ddy = -iabs(by - ay);
        sx  = (bx >= ax) ? 1 : -1;
        sy  = (by >= ay) ? 1 : -1;
        e   = ddx + ddy;
        forever begin
            exp_x.push_back(x);
            exp_y.push_back(y);
            if (x == bx && y == by) break;
            e2 = 2 * e;
            if (e2 >= ddy) begin
                e += ddy;
                x += sx;
            end
            if (e2 <= ddx) begin
                e += ddx;
                y += sy;
            end
        end
    endtask

    function automatic int pk(input int x, input int y);
        return x * 1024 + y;
    endfunction

    // mode: 0 ready high, 1 random ready, 2 stall 3 cycles on 2nd pixel,
    //       3 ready high with a second DataValid edge and x2 change mid-line
    task automatic run_line(input int ax, input int ay, input int bx, input int by,
                            input int mode);
        int  idx, cyc, stall, budget, n;
        bit  r, done_seen, poked;
        build_model(ax, ay, bx, by);
        n      = exp_x.size();
        budget = 4 * n + 40;
        x1 = COORD_W'(ax);
        y1 = COORD_W'(ay);
        x2 = COORD_W'(bx);
        y2 = COORD_W'(by);
        DataValid = 1'b1;
        step();
        chk("setup_busy", int'(busy), 1);
        chk("setup_valid", int'(pix_valid), 0);
        step();
        chk("first_valid", int'(pix_valid), 1);
        idx = 0; cyc = 0; stall = 0;
        done_seen = 1'b0; poked = 1'b0;
        while (cyc < budget) begin
            if (done) begin
                done_seen = 1'b1;
                chk("done_busy", int'(busy), 0);
                chk("done_valid", int'(pix_valid), 0);
                break;
            end
            chk("draw_valid", int'(pix_valid), 1);
            if (idx < n)
                chk("pixel", pk(int'(pix_x), int'(pix_y)), pk(exp_x[idx], exp_y[idx]));
            else
                chk("overrun", idx, n - 1);
            case (mode)
                1:       r = ($urandom_range(0, 2) != 0);
                2:       if (idx == 1 && stall < 3) begin r = 1'b0; stall++; end
                         else r = 1'b1;
                default: r = 1'b1;
            endcase
            if (mode == 3 && idx == 1 && !poked) begin
                DataValid = 1'b1;
                x2        = x2 ^ COORD_W'(5);
                poked     = 1'b1;
            end else begin
                DataValid = 1'b0;
            end
            pix_ready = r;
            step();
            if (r) idx++;
            cyc++;
        end
        DataValid = 1'b0;
        pix_ready = 1'b0;
        if (!done_seen) chk("timeout", 0, 1);
        chk("count", idx, ((iabs(bx - ax) > iabs(by - ay)) ? iabs(bx - ax) : iabs(by - ay)) + 1);
        step();
        chk("done_pulse", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_valid", int'(pix_valid), 0);
    endtask

    initial begin
        HRESETn   = 1'b0;
        DataValid = 1'b0;
        pix_ready = 1'b0;
        x1 = '0; y1 = '0; x2 = '0; y2 = '0;
        #12;
        chk("rst_x", int'(pix_x), 0);
        chk("rst_y", int'(pix_y), 0);
        chk("rst_valid", int'(pix_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        step();
        HRESETn = 1'b1;
        step();

        run_line(0, 0, 3, 0, 0);
        run_line(0, 0, 1, 3, 0);
        run_line(5, 5, 2, 2, 0);
        run_line(7, 9, 7, 9, 0);
        run_line(0, 0, 3, 0, 2);
        run_line(0, 0, 6, 2, 3);
        run_line(4, 10, 4, 2, 1);
        run_line(CMAX, 0, 0, CMAX, 0);

        // Held DataValid must not start a second line
        DataValid = 1'b1;
        x1 = 9'd1; y1 = 9'd1; x2 = 9'd2; y2 = 9'd2;
        step();
        step();
        pix_ready = 1'b1;
        repeat (6) step();
        chk("held_dv_busy", int'(busy), 0);
        chk("held_dv_valid", int'(pix_valid), 0);
        DataValid = 1'b0;
        pix_ready = 1'b0;
        step();

        // Asynchronous reset in the middle of a line
        x1 = '0; y1 = '0; x2 = 9'd8; y2 = '0;
        DataValid = 1'b1;
        step();
        step();
        DataValid = 1'b0;
        pix_ready = 1'b1;
        repeat (3) step();
        chk("pre_rst_x", int'(pix_x), 3);
        #2 HRESETn = 1'b0;
        #1;
        chk("mid_rst_x", int'(pix_x), 0);
        chk("mid_rst_valid", int'(pix_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        step();
        HRESETn = 1'b1;
        repeat (5) begin
            step();
            chk("post_rst_valid", int'(pix_valid), 0);
            chk("post_rst_busy", int'(busy), 0);
        end
        pix_ready = 1'b0;

        run_line(2, 1, 0, 4, 1);

        for (int i = 0; i < 30; i++) begin
            int lim, m;
            lim = (i % 2 == 0) ? 15 : CMAX;
            m   = (i % 3 == 0) ? 1 : 0;
            run_line($urandom_range(0, lim), $urandom_range(0, lim),
                     $urandom_range(0, lim), $urandom_range(0, lim), m);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
